// File: rtl/rv32i_packet.sv
// rv32i_packet: shadow pipeline slot, hazard FSM state and the slot/register match helper.
// Ports: none (package).
package rv32i_packet;
    import rv32i_types::*;
    typedef struct packed {
        logic                 valid;
        logic [REG_IDX_W-1:0] rd;
        logic                 regwrite;
        logic                 is_load;
    } slot_t;
    typedef enum logic {RUN, LU_STALL} hz_state_e;
    // x0 never matches, so it is never forwarded and never stalls
    function automatic logic slot_match(slot_t s, logic [REG_IDX_W-1:0] r);
        return s.valid && s.regwrite && s.rd == r && r != '0;
    endfunction
endpackage

// File: rtl/rv32i_types.sv
// rv32i_types: shared core types -- register index width and the EX-stage forward select encoding.
// Ports: none (package).
package rv32i_types;
    localparam int REG_IDX_W = 5;
    // 2'b11 is never driven
    typedef enum logic [1:0] {
        from_idex  = 2'b00,
        from_exmem = 2'b01,
        from_memwb = 2'b10
    } forward_e;
endpackage

// File: rtl/fwd_select.sv
// fwd_select: pure comparator choosing the forward source for one ALU/store operand.
// Ports: used_i (operand is register-sourced), rs_i (source index), ex_slot_i/mem_slot_i
//        (in-flight producers), fw_o (forward select, EX-stage match has priority).
module fwd_select
    import rv32i_types::*;
    import rv32i_packet::*;
(
    input  logic                 used_i,
    input  logic [REG_IDX_W-1:0] rs_i,
    input  slot_t                ex_slot_i,
    input  slot_t                mem_slot_i,
    output forward_e             fw_o
);
    logic unused_load;
    assign unused_load = ex_slot_i.is_load ^ mem_slot_i.is_load;
    always_comb fw_o = !used_i                       ? from_idex  :
                       slot_match(ex_slot_i, rs_i)   ? from_exmem :
                       slot_match(mem_slot_i, rs_i)  ? from_memwb : from_idex;
endmodule

// File: rtl/hazard_fwd_unit.sv
// hazard_fwd_unit: load-use hazard detection and registered EX forward selects for the 5-stage rv32i core.
// Ports: clk, rst (async, active-high); id_* decode info of the instruction in ID; mem_stall freezes
//        the pipeline; flush kills the ID instruction; alumux1_fw/alumux2_fw/rs2_fw registered forward
//        selects valid in EX; stall_if_id/bubble_idex combinational load-use response;
//        lu_stall_cnt/fwd_cnt performance counters present only when HAZARD_PERF_CNT_EN is defined.
module hazard_fwd_unit
    import rv32i_types::*;
    import rv32i_packet::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 id_valid,
    input  logic [REG_IDX_W-1:0] id_rs1,
    input  logic [REG_IDX_W-1:0] id_rs2,
    input  logic                 id_op1_is_rs1,
    input  logic                 id_op2_is_rs2,
    input  logic                 id_uses_rs2,
    input  logic [REG_IDX_W-1:0] id_rd,
    input  logic                 id_regwrite,
    input  logic                 id_is_load,
    input  logic                 mem_stall,
    input  logic                 flush,
    output logic [1:0]           alumux1_fw,
    output logic [1:0]           alumux2_fw,
    output logic [1:0]           rs2_fw,
    output logic                 stall_if_id,
    output logic                 bubble_idex
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0]          lu_stall_cnt,
    output logic [31:0]          fwd_cnt
`endif
);
    slot_t     ex_slot_q, ex_slot_d, mem_slot_q;
    hz_state_e state_q, state_d;
    forward_e  fw1_q, fw2_q, fw3_q, fw1_d, fw2_d, fw3_d;
    forward_e  fw1_sel, fw2_sel, fw3_sel;
    logic      hazard, lu_stall, issue, advance;

    fwd_select u_fw1 (.used_i(id_op1_is_rs1), .rs_i(id_rs1), .ex_slot_i(ex_slot_q), .mem_slot_i(mem_slot_q), .fw_o(fw1_sel));
    fwd_select u_fw2 (.used_i(id_op2_is_rs2), .rs_i(id_rs2), .ex_slot_i(ex_slot_q), .mem_slot_i(mem_slot_q), .fw_o(fw2_sel));
    fwd_select u_fw3 (.used_i(id_uses_rs2),   .rs_i(id_rs2), .ex_slot_i(ex_slot_q), .mem_slot_i(mem_slot_q), .fw_o(fw3_sel));

    // A load in EX cannot forward its data yet; any used source matching it must wait one cycle.
    assign hazard   = id_valid && ex_slot_q.is_load &&
                      ((id_op1_is_rs1 && slot_match(ex_slot_q, id_rs1)) ||
                       ((id_op2_is_rs2 || id_uses_rs2) && slot_match(ex_slot_q, id_rs2)));
    assign lu_stall = hazard && !flush;
    assign issue    = id_valid && !lu_stall && !flush;
    assign advance  = !mem_stall;

    assign stall_if_id = lu_stall;
    assign bubble_idex = lu_stall;
    assign alumux1_fw  = fw1_q;
    assign alumux2_fw  = fw2_q;
    assign rs2_fw      = fw3_q;

    // A bubble entering EX reads nothing, so its selects are all from_idex.
    always_comb begin
        ex_slot_d = issue ? slot_t'{valid: 1'b1, rd: id_rd, regwrite: id_regwrite, is_load: id_is_load} : slot_t'('0);
        fw1_d     = issue ? fw1_sel : from_idex;
        fw2_d     = issue ? fw2_sel : from_idex;
        fw3_d     = issue ? fw3_sel : from_idex;
    end

    // LU_STALL marks the cycle where the load sits in MEM and the held consumer retries.
    always_comb begin
        state_d = state_q;
        if (advance)
            state_d = (state_q == RUN && lu_stall) ? LU_STALL : RUN;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_slot_q  <= '0;
            mem_slot_q <= '0;
            state_q    <= RUN;
            fw1_q      <= from_idex;
            fw2_q      <= from_idex;
            fw3_q      <= from_idex;
        end else if (advance) begin
            mem_slot_q <= ex_slot_q;
            ex_slot_q  <= ex_slot_d;
            state_q    <= state_d;
            fw1_q      <= fw1_d;
            fw2_q      <= fw2_d;
            fw3_q      <= fw3_d;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] lu_cnt_q, fwd_cnt_q;
    logic        any_fwd;
    assign any_fwd      = fw1_d != from_idex || fw2_d != from_idex || fw3_d != from_idex;
    assign lu_stall_cnt = lu_cnt_q;
    assign fwd_cnt      = fwd_cnt_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lu_cnt_q  <= '0;
            fwd_cnt_q <= '0;
        end else if (advance) begin
            lu_cnt_q  <= lu_cnt_q + {31'd0, lu_stall};
            fwd_cnt_q <= fwd_cnt_q + {31'd0, any_fwd};
        end
    end
`endif
endmodule

// File: tb/tb_hazard_fwd_unit.sv
// tb_hazard_fwd_unit: scoreboard bench; directed pipeline scenarios then random instruction streams.
module tb_hazard_fwd_unit;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       id_valid = 1'b0, id_op1_is_rs1 = 1'b0, id_op2_is_rs2 = 1'b0, id_uses_rs2 = 1'b0;
    logic [4:0] id_rs1 = '0, id_rs2 = '0, id_rd = '0;
    logic       id_regwrite = 1'b0, id_is_load = 1'b0, mem_stall = 1'b0, flush = 1'b0;
    logic [1:0] alumux1_fw, alumux2_fw, rs2_fw;
    logic       stall_if_id, bubble_idex;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] lu_stall_cnt, fwd_cnt;
`endif

    hazard_fwd_unit dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_op1_is_rs1(id_op1_is_rs1), .id_op2_is_rs2(id_op2_is_rs2), .id_uses_rs2(id_uses_rs2),
        .id_rd(id_rd), .id_regwrite(id_regwrite), .id_is_load(id_is_load),
        .mem_stall(mem_stall), .flush(flush),
        .alumux1_fw(alumux1_fw), .alumux2_fw(alumux2_fw), .rs2_fw(rs2_fw),
        .stall_if_id(stall_if_id), .bubble_idex(bubble_idex)
`ifdef HAZARD_PERF_CNT_EN
        , .lu_stall_cnt(lu_stall_cnt), .fwd_cnt(fwd_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {bit v; bit [4:0] rd; bit wr; bit ld;} ins_t;
    typedef struct {bit st; bit [1:0] f1, f2, f3;} exp_t;

    // hist[0] is the instruction issued most recently (now in EX), hist[1] the one before (now in MEM)
    ins_t     hist[$];
    exp_t     q[$];
    bit [1:0] m_f1, m_f2, m_f3;
    int       m_lu, m_fwd;
    int       n_vec, n_bad;
    bit       mon_on, hold;

    function automatic bit writes(ins_t i, bit [4:0] r);
        return i.v && i.wr && i.rd == r && r != 0;
    endfunction

    function automatic bit [1:0] fw_of(bit used, bit [4:0] r);
        if (!used) return 2'b00;
        if (writes(hist[0], r)) return 2'b01;
        if (writes(hist[1], r)) return 2'b10;
        return 2'b00;
    endfunction

    function automatic bit lu_hit(bit used, bit [4:0] r);
        return used && hist[0].ld && writes(hist[0], r);
    endfunction

    task automatic model_reset();
        hist = '{'{0, 0, 0, 0}, '{0, 0, 0, 0}};
        m_f1 = 0; m_f2 = 0; m_f3 = 0; m_lu = 0; m_fwd = 0; hold = 0;
    endtask

    task automatic chk(string name, logic [1:0] act, logic [1:0] req);
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s t=%0t got=%0d expected=%0d", name, $time, act, req);
        end
    endtask

    // Drive one ID-stage cycle, queue what the DUT must show this cycle, then advance the model.
    task automatic step(input bit v, input bit [4:0] r1, r2, input bit o1, o2, u2,
                        input bit [4:0] rd, input bit wr, ld, ms, fl);
        exp_t e;
        bit iss;
        bit [1:0] n1, n2, n3;
        id_valid = v; id_rs1 = r1; id_rs2 = r2; id_op1_is_rs1 = o1; id_op2_is_rs2 = o2;
        id_uses_rs2 = u2; id_rd = rd; id_regwrite = wr; id_is_load = ld; mem_stall = ms; flush = fl;
        e.st = v && (lu_hit(o1, r1) || lu_hit(o2 || u2, r2)) && !fl;
        e.f1 = m_f1; e.f2 = m_f2; e.f3 = m_f3;
        q.push_back(e);
        if (!ms) begin
            iss = v && !e.st && !fl;
            n1 = iss ? fw_of(o1, r1) : 2'b00;
            n2 = iss ? fw_of(o2, r2) : 2'b00;
            n3 = iss ? fw_of(u2, r2) : 2'b00;
            if (e.st) m_lu++;
            if (n1 != 0 || n2 != 0 || n3 != 0) m_fwd++;
            hist.push_front('{iss, rd, wr, ld});
            void'(hist.pop_back());
            m_f1 = n1; m_f2 = n2; m_f3 = n3;
        end
        hold = (e.st || ms) && !fl;
        @(posedge clk); #2;
    endtask

    task automatic nop();
        step(1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0);
    endtask

    always @(negedge clk) begin
        if (mon_on) begin
            n_vec++;
            if (q.size() == 0) begin
                n_bad++;
                $display("FAIL scoreboard_empty t=%0t got=none expected=entry", $time);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("stall_if_id", {1'b0, stall_if_id}, {1'b0, e.st});
                chk("bubble_idex", {1'b0, bubble_idex}, {1'b0, e.st});
                chk("alumux1_fw", alumux1_fw, e.f1);
                chk("alumux2_fw", alumux2_fw, e.f2);
                chk("rs2_fw", rs2_fw, e.f3);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog t=%0t got=running expected=finished", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        bit rv, o1, o2, u2, wr, ld;
        bit [4:0] rs1, rs2, rd;
        model_reset();
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        mon_on = 1;
        // back-to-back: add x5,x1,x2 ; sub x6,x5,x1
        step(1, 1, 2, 1, 1, 0, 5, 1, 0, 0, 0);
        step(1, 5, 1, 1, 1, 0, 6, 1, 0, 0, 0);
        nop();
        // distance 2: add x5 ; bubble ; and x7,x1,x5
        step(1, 1, 2, 1, 1, 0, 5, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 1, 5, 1, 1, 0, 7, 1, 0, 0, 0);
        nop();
        // load-use: lw x3 ; add x4,x3,x2 (stalled, then retried)
        step(1, 1, 0, 1, 0, 0, 3, 1, 1, 0, 0);
        step(1, 3, 2, 1, 1, 0, 4, 1, 0, 0, 0);
        step(1, 3, 2, 1, 1, 0, 4, 1, 0, 0, 0);
        nop();
        // x0 destination: addi x0 ; add x1,x0,x0
        step(1, 1, 0, 1, 0, 0, 0, 1, 0, 0, 0);
        step(1, 0, 0, 1, 1, 0, 1, 1, 0, 0, 0);
        nop();
        // store data after load: lw x2 ; sw x2 (rs2 used for data only)
        step(1, 1, 0, 1, 0, 0, 2, 1, 1, 0, 0);
        step(1, 1, 2, 1, 0, 1, 0, 0, 0, 0, 0);
        step(1, 1, 2, 1, 0, 1, 0, 0, 0, 0, 0);
        nop();
        // freeze during load-use, then flush on release
        step(1, 1, 0, 1, 0, 0, 3, 1, 1, 0, 0);
        repeat (3) step(1, 3, 2, 1, 1, 0, 4, 1, 0, 1, 0);
        step(1, 3, 2, 1, 1, 0, 4, 1, 0, 0, 1);
        nop();
        nop();
        for (int i = 0; i < 400; i++) begin
            if (!hold) begin
                rv = $urandom_range(0, 9) != 0;
                rs1 = 5'($urandom_range(0, 3)); rs2 = 5'($urandom_range(0, 3)); rd = 5'($urandom_range(0, 3));
                o1 = $urandom_range(0, 4) != 0; o2 = 1'($urandom_range(0, 1)); u2 = $urandom_range(0, 2) == 0;
                wr = $urandom_range(0, 4) != 0; ld = $urandom_range(0, 2) == 0;
            end
            step(rv, rs1, rs2, o1, o2, u2, rd, wr, ld, $urandom_range(0, 6) == 0, $urandom_range(0, 9) == 0);
        end
        nop();
        nop();
`ifdef HAZARD_PERF_CNT_EN
        n_vec += 2;
        if (lu_stall_cnt !== 32'(m_lu)) begin n_bad++; $display("FAIL lu_stall_cnt got=%0d expected=%0d", lu_stall_cnt, m_lu); end
        if (fwd_cnt !== 32'(m_fwd)) begin n_bad++; $display("FAIL fwd_cnt got=%0d expected=%0d", fwd_cnt, m_fwd); end
`endif
        // async reset while in LU_STALL with the load in MEM
        step(1, 1, 0, 1, 0, 0, 3, 1, 1, 0, 0);
        step(1, 3, 2, 1, 1, 0, 4, 1, 0, 0, 0);
        mon_on = 0;
        rst = 1'b1;
        #1;
        n_vec++;
        chk("rst_alumux1_fw", alumux1_fw, 2'b00);
        chk("rst_alumux2_fw", alumux2_fw, 2'b00);
        chk("rst_rs2_fw", rs2_fw, 2'b00);
        chk("rst_stall_if_id", {1'b0, stall_if_id}, 2'b00);
        chk("rst_bubble_idex", {1'b0, bubble_idex}, 2'b00);
`ifdef HAZARD_PERF_CNT_EN
        chk("rst_lu_stall_cnt", lu_stall_cnt[1:0], 2'b00);
`endif
        @(posedge clk); #2 rst = 1'b0;
        model_reset();
        mon_on = 1;
        // retried consumer after reset: the load is gone, nothing to forward
        step(1, 3, 2, 1, 1, 0, 4, 1, 0, 0, 0);
        nop();
        nop();
        mon_on = 0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
